// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures GRF operands with a W->D bypass and presents them to EX one cycle later.
// hold freezes E (write-back still snooped into operands), bubble loads a NOP over hold; BUBBLE_CNT_EN adds bubble_cnt.
module id_ex_pipe_reg #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          hold,
    input  logic          bubble,
    input  logic [DW-1:0] instr_d,
    input  logic [DW-1:0] pc8_d,
    input  logic [DW-1:0] imm_d,
    input  logic [AW-1:0] a1_d,
    input  logic [AW-1:0] a2_d,
    input  logic [AW-1:0] a3_d,
    input  logic [1:0]    tnew_d,
    input  logic [DW-1:0] rd1_d,
    input  logic [DW-1:0] rd2_d,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_a3,
    input  logic [DW-1:0] wb_wd,
    output logic          valid_e,
    output logic [DW-1:0] instr_e,
    output logic [DW-1:0] pc8_e,
    output logic [DW-1:0] imm_e,
    output logic [AW-1:0] a1_e,
    output logic [AW-1:0] a2_e,
    output logic [AW-1:0] a3_e,
    output logic [1:0]    tnew_e,
    output logic [DW-1:0] rs_e,
    output logic [DW-1:0] rt_e
`ifdef BUBBLE_CNT_EN
    ,
    output logic [31:0]   bubble_cnt
`endif
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc8;
        logic [DW-1:0] imm;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] a3;
        logic [1:0]    tnew;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
    } e_stage_t;

    e_stage_t e_q;
    e_stage_t e_d;

    // $0 is never written, so a write-back addressed to it must not be forwarded.
    function automatic logic wb_hit(input logic [AW-1:0] addr);
        return wb_we && (wb_a3 != '0) && (wb_a3 == addr);
    endfunction

    always_comb begin
        e_d = e_q;
        if (bubble) begin
            e_d = '0;
        end else if (!hold) begin
            e_d.valid = 1'b1;
            e_d.instr = instr_d;
            e_d.pc8   = pc8_d;
            e_d.imm   = imm_d;
            e_d.a1    = a1_d;
            e_d.a2    = a2_d;
            e_d.a3    = a3_d;
            e_d.tnew  = tnew_d;
            e_d.rs    = wb_hit(a1_d) ? wb_wd : rd1_d;
            e_d.rt    = wb_hit(a2_d) ? wb_wd : rd2_d;
        end else begin
            // Held operands track write-back so they are current when EX releases.
            if (wb_hit(e_q.a1)) e_d.rs = wb_wd;
            if (wb_hit(e_q.a2)) e_d.rt = wb_wd;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign valid_e = e_q.valid;
    assign instr_e = e_q.instr;
    assign pc8_e   = e_q.pc8;
    assign imm_e   = e_q.imm;
    assign a1_e    = e_q.a1;
    assign a2_e    = e_q.a2;
    assign a3_e    = e_q.a3;
    assign tnew_e  = e_q.tnew;
    assign rs_e    = e_q.rs;
    assign rt_e    = e_q.rt;

`ifdef BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
